// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame geometry and
// the keyboard command/response byte values used by the host and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DISABLE  = 8'hF5;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT      = 8'hAA;

    // Bits shifted out after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length debounce: the output level
// follows the pin only after P_FILTER_LEN consecutive samples that disagree with it.
module ps2_line_filter #(
    parameter int P_FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level
);

    localparam int CW = $clog2(P_FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(P_FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, sends one byte on
// device-generated clock falls, samples the device ACK and reports status.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int P_INHIBIT_CYCLES = 10000,
    parameter int P_TIMEOUT_CYCLES = 1500000,
    parameter int P_FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_ok,
    output logic       o_err
);

    localparam int CNT_MAX = (P_TIMEOUT_CYCLES > P_INHIBIT_CYCLES) ? P_TIMEOUT_CYCLES : P_INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [3:0] STOP_IDX = 4'(FRAME_LEN - 2);

    state_t             r_state, w_state_next;
    logic [9:0]         r_frame, w_frame_next;
    logic [3:0]         r_idx, w_idx_next, w_idx_inc;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_clk_oe, w_clk_oe_next;
    logic               r_data_oe, w_data_oe_next;
    logic               r_done, w_done_next;
    logic               r_ack_ok, w_ack_ok_next;
    logic               r_err, w_err_next;
    logic               r_nack, w_nack_next;
    logic               r_clk_prev;
    logic               w_clk_filt, w_data_filt, w_fall, w_timeout;

    ps2_line_filter #(.P_FILTER_LEN(P_FILTER_LEN)) u_clk_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_ps2_clk),
        .o_level (w_clk_filt)
    );

    ps2_line_filter #(.P_FILTER_LEN(P_FILTER_LEN)) u_data_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_ps2_data),
        .o_level (w_data_filt)
    );

    assign w_fall    = r_clk_prev & ~w_clk_filt;
    assign w_timeout = (r_cnt == CNT_W'(P_TIMEOUT_CYCLES - 1));
    assign w_idx_inc = r_idx + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_err      <= 1'b0;
            r_nack     <= 1'b0;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            r_idx      <= w_idx_next;
            r_cnt      <= w_cnt_next;
            r_clk_oe   <= w_clk_oe_next;
            r_data_oe  <= w_data_oe_next;
            r_done     <= w_done_next;
            r_ack_ok   <= w_ack_ok_next;
            r_err      <= w_err_next;
            r_nack     <= w_nack_next;
            r_clk_prev <= w_clk_filt;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_frame_next   = r_frame;
        w_idx_next     = r_idx;
        w_cnt_next     = r_cnt;
        w_clk_oe_next  = r_clk_oe;
        w_data_oe_next = r_data_oe;
        w_done_next    = 1'b0;
        w_ack_ok_next  = r_ack_ok;
        w_err_next     = r_err;
        w_nack_next    = r_nack;

        case (r_state)
            ST_IDLE: begin
                if (i_tx_valid) begin
                    w_frame_next  = make_frame(i_tx_data);
                    w_ack_ok_next = 1'b0;
                    w_err_next    = 1'b0;
                    w_nack_next   = 1'b0;
                    w_cnt_next    = '0;
                    w_clk_oe_next = 1'b1;
                    w_state_next  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == CNT_W'(P_INHIBIT_CYCLES - 1)) begin
                    // Clock release and start bit happen on the same edge.
                    w_clk_oe_next  = 1'b0;
                    w_data_oe_next = 1'b1;
                    w_cnt_next     = '0;
                    w_idx_next     = '0;
                    w_state_next   = ST_START;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_START, ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (w_timeout) begin
                    w_clk_oe_next  = 1'b0;
                    w_data_oe_next = 1'b0;
                    w_err_next     = 1'b1;
                    w_ack_ok_next  = 1'b0;
                    w_done_next    = 1'b1;
                    w_state_next   = ST_IDLE;
                end else if (r_state == ST_START) begin
                    if (w_fall) begin
                        w_data_oe_next = ~r_frame[0];
                        w_state_next   = ST_SEND;
                    end
                end else if (r_state == ST_SEND) begin
                    if (w_fall) begin
                        w_idx_next     = w_idx_inc;
                        w_data_oe_next = ~r_frame[w_idx_inc];
                        if (w_idx_inc == STOP_IDX) begin
                            w_state_next = ST_ACK;
                        end
                    end
                end else if (r_state == ST_ACK) begin
                    if (w_fall) begin
                        w_ack_ok_next = ~w_data_filt;
                        w_nack_next   = w_data_filt;
                        w_state_next  = ST_WAIT_IDLE;
                    end
                end else if (w_clk_filt && w_data_filt) begin
                    w_done_next  = 1'b1;
                    w_err_next   = r_nack;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_tx_ready    = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign o_done        = r_done;
    assign o_ack_ok      = r_ack_ok;
    assign o_err         = r_err;

endmodule
